ray_column_sequencer: RTL

- Consumes the player pose registers driven by the NIOS PIO output ports (player_x, player_y, player_angle) and the frame-start strobe from the VGA timing block.
- Snapshots the pose once per frame.
- Issues one ray request per screen column to the raycast core over a valid/ready handshake, generating per-column ray angles incrementally.
- Reports frame completion and counts frames it had to drop.

---
 rtl/ray_column_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ray_column_sequencer.sv
// ray_column_sequencer
// Takes a snapshot of the player pose once per frame, then sends one ray
// request per screen column to the raycast core over a valid/ready
// handshake. Each column's ray angle is produced by adding ANGLE_STEP to the
// previous one. Frame completion is signalled with a one-cycle frame_done
// pulse. Each frame_start that arrives while a frame is still being issued
// is counted in a saturating overrun counter.

module ray_column_sequencer #(
  parameter int NUM_COLS   = 640,
  parameter int COL_W      = 10,
  parameter int ANGLE_W    = 12,
  parameter int ANGLE_STEP = 1,
  parameter int POS_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [POS_W-1:0]   player_x,
  input  logic [POS_W-1:0]   player_y,
  input  logic [ANGLE_W-1:0] player_angle,
  input  logic               frame_start,
  output logic               ray_valid,
  input  logic               ray_ready,
  output logic [COL_W-1:0]   ray_col,
  output logic [POS_W-1:0]   ray_x,
  output logic [POS_W-1:0]   ray_y,
  output logic [ANGLE_W-1:0] ray_angle,
  output logic               busy,
  output logic               frame_done,
  output logic [7:0]         overrun_cnt
);

  // Elaboration-time sanity checks on the geometry parameters.
  if (NUM_COLS < 2) begin : g_bad_cols
    $error("ray_column_sequencer: NUM_COLS must be at least 2");
  end
  if ((64'd1 << COL_W) < 64'(NUM_COLS)) begin : g_bad_col_w
    $error("ray_column_sequencer: COL_W too narrow for NUM_COLS");
  end

  // Column 0 looks half a field of view to the left of the heading.
  // Truncating to ANGLE_W bits gives the value modulo one full circle.
  localparam logic [ANGLE_W-1:0] HALF_FOV  = ANGLE_W'((NUM_COLS / 2) * ANGLE_STEP);
  localparam logic [ANGLE_W-1:0] STEP_A    = ANGLE_W'(ANGLE_STEP);
  localparam logic [COL_W-1:0]   LAST_COL  = COL_W'(NUM_COLS - 1);
  localparam logic [COL_W-1:0]   COL_ONE   = COL_W'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic               ray_valid_nxt;
  logic [COL_W-1:0]   ray_col_nxt;
  logic [POS_W-1:0]   ray_x_nxt;
  logic [POS_W-1:0]   ray_y_nxt;
  logic [ANGLE_W-1:0] ray_angle_nxt;
  logic               busy_nxt;
  logic               frame_done_nxt;
  logic [7:0]         overrun_cnt_nxt;
  logic               handshake;

  // Increment that sticks at all-ones, so the counter never wraps to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Angle arithmetic wraps silently at the top of the circle.
  function automatic logic [ANGLE_W-1:0] angle_add(input logic [ANGLE_W-1:0] a,
                                                   input logic [ANGLE_W-1:0] b);
    logic [ANGLE_W-1:0] s;
    s = a + b;
    return s;
  endfunction

  function automatic logic [ANGLE_W-1:0] angle_sub(input logic [ANGLE_W-1:0] a,
                                                   input logic [ANGLE_W-1:0] b);
    logic [ANGLE_W-1:0] d;
    d = a - b;
    return d;
  endfunction

  assign handshake = ray_valid && ray_ready;

  // Next-state and next-output logic. Every output is computed here and
  // then registered, so ray_valid never depends combinationally on ray_ready.
  always_comb begin
    state_nxt       = state;
    ray_valid_nxt   = ray_valid;
    ray_col_nxt     = ray_col;
    ray_x_nxt       = ray_x;
    ray_y_nxt       = ray_y;
    ray_angle_nxt   = ray_angle;
    busy_nxt        = busy;
    frame_done_nxt  = 1'b0;
    overrun_cnt_nxt = overrun_cnt;

    case (state)
      IDLE: begin
        if (frame_start) begin
          ray_x_nxt     = player_x;
          ray_y_nxt     = player_y;
          ray_angle_nxt = angle_sub(player_angle, HALF_FOV);
          ray_col_nxt   = '0;
          ray_valid_nxt = 1'b1;
          busy_nxt      = 1'b1;
          state_nxt     = ISSUE;
        end
      end

      ISSUE: begin
        // A new frame cannot begin until this one finishes. The request is
        // ignored but counted, including one that lands on the final
        // handshake.
        if (frame_start) begin
          overrun_cnt_nxt = sat_inc8(overrun_cnt);
        end
        if (handshake) begin
          if (ray_col == LAST_COL) begin
            ray_valid_nxt  = 1'b0;
            busy_nxt       = 1'b0;
            frame_done_nxt = 1'b1;
            state_nxt      = IDLE;
          end else begin
            ray_col_nxt   = ray_col + COL_ONE;
            ray_angle_nxt = angle_add(ray_angle, STEP_A);
          end
        end
      end

      default: begin
        state_nxt     = IDLE;
        ray_valid_nxt = 1'b0;
        busy_nxt      = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ray_valid   <= 1'b0;
      ray_col     <= '0;
      ray_x       <= '0;
      ray_y       <= '0;
      ray_angle   <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun_cnt <= 8'd0;
    end else begin
      state       <= state_nxt;
      ray_valid   <= ray_valid_nxt;
      ray_col     <= ray_col_nxt;
      ray_x       <= ray_x_nxt;
      ray_y       <= ray_y_nxt;
      ray_angle   <= ray_angle_nxt;
      busy        <= busy_nxt;
      frame_done  <= frame_done_nxt;
      overrun_cnt <= overrun_cnt_nxt;
    end
  end

endmodule
